matrix_vector_mac_seq: RTL

MATRIX_VECTOR_MAC_SEQ -- requirements
Module: matrix_vector_mac_seq

---
 rtl/matrix_vector_mac_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/matrix_vector_mac_seq.sv
// Sequential M x N matrix-vector MAC: one column per cycle, M multipliers in parallel.
// Result valid N+1 cycles after the input handshake; it holds in DONE until out_ready, and new input is refused until then.
module matrix_vector_mac_seq #(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  localparam int ACC_W = 2*DW + $clog2(N+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW*N*M-1:0]    matrix_inp,
  input  logic [DW*N-1:0]      vector_inp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W*M-1:0]   outp,
  output logic                 busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [DW*N*M-1:0]   mat_q;
  logic [DW*N-1:0]     vec_q;
  logic [CW-1:0]       col;
  logic [ACC_W*M-1:0]  acc;
  logic [ACC_W*M-1:0]  prod;
  logic                last_col;

  // Extending both operands to ACC_W makes the truncated ACC_W product exact in either mode.
  function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] x);
    if (SIGNED != 0) return {{(ACC_W-DW){x[DW-1]}}, x};
    return {{(ACC_W-DW){1'b0}}, x};
  endfunction

  assign last_col  = (col == CW'(N-1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign outp      = acc;

  always_comb begin
    prod = '0;
    for (int i = 0; i < M; i++) begin
      prod[ACC_W*i +: ACC_W] = ext(mat_q[DW*(N*i + int'(col)) +: DW]) *
                               ext(vec_q[DW*int'(col) +: DW]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_col)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mat_q <= '0;
      vec_q <= '0;
      acc   <= '0;
      col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mat_q <= matrix_inp;
            vec_q <= vector_inp;
            acc   <= '0;
            col   <= '0;
          end
        end
        BUSY: begin
          for (int i = 0; i < M; i++) begin
            acc[ACC_W*i +: ACC_W] <= acc[ACC_W*i +: ACC_W] + prod[ACC_W*i +: ACC_W];
          end
          col <= last_col ? '0 : col + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
